fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the instruction decoder (ctrl).
- Owns the PC, drives the instruction-memory read address, and captures the instruction and PC into IF/ID.
- Handles stall, flush, branch/jump redirect and halt.
- The ID-stage decoder consumes o_if_id_inst; its halt output returns here as i_halt.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when the entry is invalid.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_stall  input  1  hazard-unit stall; holds PC and IF/ID.
- i_flush  input  1  squash the current IF/ID entry.
- i_redirect_valid  input  1  taken branch or jump resolved in EX.
- i_redirect_pc  input  32  redirect target address.
- i_halt  input  1  decoder halt for a valid ID instruction (EBREAK or trap).
- o_imem_raddr  output  32  instruction-memory read address; equals the PC register.
- i_imem_rdata  input  32  instruction word, combinational read of o_imem_raddr in the same cycle.
- o_if_id_valid  output  1  IF/ID holds a real instruction.
- o_if_id_inst  output  32  instruction to the decoder.
- o_if_id_pc  output  32  PC of that instruction.
- o_if_id_pc4  output  32  PC+4 of that instruction, used as the JAL/JALR link value.
- o_if_id_misalign  output  1  fetch address was not word-aligned; feeds trap logic.
- o_halted  output  1  fetch is stopped in the HALTED state.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - pc=RESET_ADDR, state=RUN.
  - o_if_id_valid=0, o_if_id_inst=NOP_INST, o_if_id_pc=0, o_if_id_pc4=0, o_if_id_misalign=0, o_halted=0.
  - Reset applied mid-operation overrides every other input.
- o_imem_raddr = pc, combinational from the register. Fetch latency is one cycle: the word read in cycle N appears on IF/ID outputs in cycle N+1.
- States:
  - RUN: normal operation.
  - HALTED: terminal; left only by reset.
- Priority per edge in RUN: redirect > halt > stall > flush > normal.
  - Redirect (i_redirect_valid=1): pc<=i_redirect_pc; IF/ID<=bubble (valid=0, inst=NOP_INST, misalign=0). Takes precedence over a simultaneous stall or halt, because the instruction in ID is wrong-path.
  - Halt (i_halt=1, no redirect): pc holds; IF/ID<=bubble; state<=HALTED; o_halted=1 from the next cycle.
  - Stall (i_stall=1, no redirect/halt): pc and all IF/ID fields hold, even if i_flush=1.
  - Flush (i_flush=1 only): IF/ID<=bubble; pc<=pc+4. The fetched word is discarded.
  - Normal: IF/ID<={valid=1, inst=i_imem_rdata, pc, pc+4, misalign=0}; pc<=pc+4.
- Misaligned fetch: if pc[1:0]!=0 on a normal capture, the entry is captured with valid=1, inst=NOP_INST, misalign=1, and pc<=pc+4 as normal. Alignment is never corrected.
- HALTED: pc, IF/ID and o_halted are frozen; all inputs except reset are ignored.
- Arithmetic: pc+4 is 32-bit unsigned and wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). o_if_id_pc4 uses the same wrap.
- No combinational path from any input to any output other than i_imem_rdata through the registers.

Decomposition:
- Shared package cpu_pkg: NOP_INST and RESET_ADDR defaults, plus the fetch state encoding (RUN=1'b0, HALTED=1'b1).
- One sub-module, if_id_reg: the IF/ID register with load/hold/bubble controls and a synchronous active-low reset. It is reused for later pipeline registers.
- The PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then 3 free-running cycles, imem returning 0xA,0xB,0xC:
  - raddr reads 0,4,8.
  - IF/ID shows (inst 0xA, pc 0, pc4 4), then (0xB, 4, 8).
  - valid=0 in the first post-reset cycle.
- i_stall=1 for 2 cycles at pc=8: raddr stays 8, IF/ID holds (0xB, 4); releasing the stall resumes with 0xC at pc 8.
- Redirect to 0x100 together with i_stall=1 and i_halt=1:
  - next cycle raddr=0x100, IF/ID valid=0 with NOP_INST, o_halted=0.
  - the following cycle IF/ID pc=0x100.
- i_halt=1 at pc=0x20: pc frozen at 0x20, IF/ID bubble, o_halted=1 for 10 cycles despite redirect/flush pulses; i_rst_n=0 then restores pc=0, o_halted=0.
- Redirect to 0x102: next capture has valid=1, misalign=1, inst=NOP_INST, pc=0x102; raddr then reads 0x106.
- Wrap: redirect to 0xFFFF_FFFC then one normal cycle: o_if_id_pc4=0, raddr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/bubble constants and the fetch state encoding.
package cpu_pkg;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT   = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;  // wraps modulo 2^32
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register between two stages: bubble beats load, otherwise hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic        i_valid,
    input  logic [31:0] i_inst,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    input  logic        i_misalign,
    output logic        o_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_misalign
);

    logic        r_valid;
    logic [31:0] r_inst;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic        r_misalign;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_pc       <= 32'd0;
            r_pc4      <= 32'd0;
            r_misalign <= 1'b0;
        end else if (i_bubble) begin
            // pc/pc4 are don't-care on a bubble; holding them saves enables
            r_valid    <= 1'b0;
            r_inst     <= NOP_INST;
            r_misalign <= 1'b0;
        end else if (i_load) begin
            r_valid    <= i_valid;
            r_inst     <= i_inst;
            r_pc       <= i_pc;
            r_pc4      <= i_pc4;
            r_misalign <= i_misalign;
        end
    end

    assign o_valid    = r_valid;
    assign o_inst     = r_inst;
    assign o_pc       = r_pc;
    assign o_pc4      = r_pc4;
    assign o_misalign = r_misalign;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, handles redirect/halt/stall/flush, feeds IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
    parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_id_valid,
    output logic [31:0] o_if_id_inst,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_misalign,
    output logic        o_halted
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_halted;

    logic         w_run;
    logic         w_bubble;
    logic         w_load;
    logic         w_misalign;
    logic [31:0]  w_inst;
    logic [31:0]  w_pc4;

    assign w_pc4      = pc_plus4(r_pc);
    assign w_misalign = |r_pc[1:0];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_run    = 1'b0;
        w_bubble = 1'b0;
        w_load   = 1'b0;
        w_inst   = i_imem_rdata;
        w_run    = (r_state == FETCH_RUN);
        // a stall outranks flush, so a stalled flush leaves IF/ID untouched
        w_bubble = w_run && (i_redirect_valid || i_halt || (!i_stall && i_flush));
        w_load   = w_run && !i_redirect_valid && !i_halt && !i_stall && !i_flush;
        if (w_misalign) w_inst = NOP_INST;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc     <= RESET_ADDR;
            r_state  <= FETCH_RUN;
            r_halted <= 1'b0;
        end else if (r_state == FETCH_RUN) begin
            if (i_redirect_valid) begin
                r_pc <= i_redirect_pc;
            end else if (i_halt) begin
                r_state  <= FETCH_HALTED;
                r_halted <= 1'b1;
            end else if (!i_stall) begin
                r_pc <= w_pc4;
            end
        end
    end

    if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_load),
        .i_bubble   (w_bubble),
        .i_valid    (1'b1),
        .i_inst     (w_inst),
        .i_pc       (r_pc),
        .i_pc4      (w_pc4),
        .i_misalign (w_misalign),
        .o_valid    (o_if_id_valid),
        .o_inst     (o_if_id_inst),
        .o_pc       (o_if_id_pc),
        .o_pc4      (o_if_id_pc4),
        .o_misalign (o_if_id_misalign)
    );

    assign o_imem_raddr = r_pc;
    assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction memory.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_misalign;
    logic        halted;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_stage dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stall          (stall),
        .i_flush          (flush),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .i_halt           (halt),
        .o_imem_raddr     (imem_raddr),
        .i_imem_rdata     (imem_rdata),
        .o_if_id_valid    (if_id_valid),
        .o_if_id_inst     (if_id_inst),
        .o_if_id_pc       (if_id_pc),
        .o_if_id_pc4      (if_id_pc4),
        .o_if_id_misalign (if_id_misalign),
        .o_halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Words 0xA/0xB/0xC at 0/4/8, elsewhere a tag derived from the address.
    always_comb begin
        case (imem_raddr)
            32'h0:   imem_rdata = 32'h0000_000A;
            32'h4:   imem_rdata = 32'h0000_000B;
            32'h8:   imem_rdata = 32'h0000_000C;
            default: imem_rdata = 32'h1000_0000 | imem_raddr;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0; halt = 0;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        step();
        step();
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_inst", if_id_inst, NOP);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_pc4", if_id_pc4, 32'd0);
        check("rst_mis", {31'd0, if_id_misalign}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_raddr", imem_raddr, 32'd0);

        // free run
        rst_n = 1;
        step();
        check("run1_raddr", imem_raddr, 32'h4);
        check("run1_valid", {31'd0, if_id_valid}, 32'd1);
        check("run1_inst", if_id_inst, 32'hA);
        check("run1_pc", if_id_pc, 32'h0);
        check("run1_pc4", if_id_pc4, 32'h4);
        step();
        check("run2_raddr", imem_raddr, 32'h8);
        check("run2_inst", if_id_inst, 32'hB);
        check("run2_pc", if_id_pc, 32'h4);
        check("run2_pc4", if_id_pc4, 32'h8);

        // stall two cycles
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_raddr", imem_raddr, 32'h8);
            check("stall_inst", if_id_inst, 32'hB);
            check("stall_pc", if_id_pc, 32'h4);
        end
        stall = 0;
        step();
        check("resume_inst", if_id_inst, 32'hC);
        check("resume_pc", if_id_pc, 32'h8);
        check("resume_raddr", imem_raddr, 32'hC);

        // redirect beats stall and halt
        redirect_valid = 1; redirect_pc = 32'h100; stall = 1; halt = 1;
        step();
        idle_inputs();
        check("redir_raddr", imem_raddr, 32'h100);
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_inst", if_id_inst, NOP);
        check("redir_halted", {31'd0, halted}, 32'd0);
        step();
        check("redir_next_pc", if_id_pc, 32'h100);
        check("redir_next_inst", if_id_inst, 32'h1000_0100);
        check("redir_next_valid", {31'd0, if_id_valid}, 32'd1);

        // flush drops the fetched word but advances pc
        flush = 1;
        step();
        flush = 0;
        check("flush_valid", {31'd0, if_id_valid}, 32'd0);
        check("flush_inst", if_id_inst, NOP);
        check("flush_raddr", imem_raddr, 32'h108);
        step();
        check("post_flush_pc", if_id_pc, 32'h108);
        // stall outranks flush
        stall = 1; flush = 1;
        step();
        idle_inputs();
        check("stallflush_valid", {31'd0, if_id_valid}, 32'd1);
        check("stallflush_pc", if_id_pc, 32'h108);
        check("stallflush_raddr", imem_raddr, 32'h10C);

        // halt at 0x20
        redirect_valid = 1; redirect_pc = 32'h20;
        step();
        idle_inputs();
        check("pre_halt_raddr", imem_raddr, 32'h20);
        halt = 1;
        step();
        halt = 0;
        for (int i = 0; i < 10; i++) begin
            check("halt_raddr", imem_raddr, 32'h20);
            check("halt_valid", {31'd0, if_id_valid}, 32'd0);
            check("halt_halted", {31'd0, halted}, 32'd1);
            redirect_valid = (i % 2 == 0);
            redirect_pc    = 32'h200;
            flush          = (i % 2 == 1);
            step();
        end
        idle_inputs();
        rst_n = 0;
        step();
        rst_n = 1;
        check("unhalt_raddr", imem_raddr, 32'h0);
        check("unhalt_halted", {31'd0, halted}, 32'd0);

        // misaligned redirect
        redirect_valid = 1; redirect_pc = 32'h102;
        step();
        idle_inputs();
        check("mis_raddr0", imem_raddr, 32'h102);
        step();
        check("mis_valid", {31'd0, if_id_valid}, 32'd1);
        check("mis_flag", {31'd0, if_id_misalign}, 32'd1);
        check("mis_inst", if_id_inst, NOP);
        check("mis_pc", if_id_pc, 32'h102);
        check("mis_raddr1", imem_raddr, 32'h106);

        // wrap around
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_id_pc4, 32'h0);
        check("wrap_raddr", imem_raddr, 32'h0);
        check("wrap_mis", {31'd0, if_id_misalign}, 32'd0);

        // reset overrides a simultaneous redirect
        rst_n = 0; redirect_valid = 1; redirect_pc = 32'h400;
        step();
        idle_inputs();
        rst_n = 1;
        check("rst_over_raddr", imem_raddr, 32'h0);
        check("rst_over_valid", {31'd0, if_id_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
